// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces a
// single-key press/release over column dwell samples and emits a hex key code.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, srow_q;
    logic [CW-1:0]   div_q, div_d;
    logic [3:0]      col_q, col_d;
    logic [3:0]      pat_q, pat_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [3:0]      key_q, key_d;
    logic            key_valid_q, key_valid_d;
    logic            key_down_q, key_down_d;

    logic            sample;
    logic            rotate;
    logic            row_valid;
    logic [DW-1:0]   deb_inc;
    logic            deb_done;

    // Position of the single low bit in an active-low one-hot vector.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hF;  default: key_code = 4'hD;
        endcase
    endfunction

    assign sample    = (div_q == CW'(SCAN_DIV - 1));
    assign row_valid = (srow_q == 4'b1110) || (srow_q == 4'b1101) ||
                       (srow_q == 4'b1011) || (srow_q == 4'b0111);
    assign deb_inc   = deb_q + DW'(1);
    assign deb_done  = (deb_inc == DW'(DEBOUNCE_CNT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 4'hF;
            srow_q      <= 4'hF;
            div_q       <= '0;
            state_q     <= SCAN;
            col_q       <= 4'b1110;
            pat_q       <= 4'hF;
            deb_q       <= '0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            sync1_q     <= row;
            srow_q      <= sync1_q;
            div_q       <= div_d;
            state_q     <= state_d;
            col_q       <= col_d;
            pat_q       <= pat_d;
            deb_q       <= deb_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        deb_d       = deb_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        rotate      = 1'b0;
        // Dwell wraps at every sample, so a column change always restarts it.
        div_d       = sample ? '0 : div_q + CW'(1);

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (row_valid) begin
                        pat_d   = srow_q;
                        deb_d   = DW'(1);
                        state_d = DEB_PRESS;
                    end else begin
                        rotate = 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (srow_q == pat_q) begin
                        deb_d = deb_inc;
                        if (deb_done) begin
                            key_d       = key_code(low_index(pat_q), low_index(col_q));
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = PRESSED;
                        end
                    end else begin
                        state_d = SCAN;
                        rotate  = 1'b1;
                    end
                end
                PRESSED: begin
                    if (srow_q == 4'hF) begin
                        deb_d   = DW'(1);
                        state_d = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (srow_q == 4'hF) begin
                        deb_d = deb_inc;
                        if (deb_done) begin
                            key_down_d = 1'b0;
                            state_d    = SCAN;
                            rotate     = 1'b1;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        col_d = rotate ? {col_q[2:0], col_q[3]} : col_q;
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: a keypad model shorts rows to driven columns; expected key
// codes are queued at stimulus time and popped by a monitor on each key_valid.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    logic        prev_valid = 1'b0;
    logic [3:0]  last_key;
    int          errors = 0;
    int          checks = 0;

    // Key legend indexed by row*4 + column.
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // A pressed switch pulls its row low whenever its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        checks++;
        if (!(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
            errors++;
            $display("FAIL col_onehot: col=%b, required exactly one low bit", col);
        end
        if (key_valid) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_consecutive: key_valid high two cycles, required one");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: key=%h key_down=%b, required no pulse", key, key_down);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key !== mon_exp || key_down !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse_key: key=%h key_down=%b, required key=%h key_down=1",
                             key, key_down, mon_exp);
                end else begin
                    $display("pulse key=%h ok", key);
                end
            end
        end
        prev_valid = key_valid;
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses missing after %0d cycles, required 0",
                     name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        int idx;
        int hold;
        bit long_press;
        logic [3:0] exp_col;
        logic [3:0] col_snap;
        bit moved;

        rst_n   = 1'b0;
        pressed = '0;
        cycles(3);
        check("reset_col", col, 4'b1110);
        check("reset_key", key, 4'h0);
        check("reset_valid", key_valid, 0);
        check("reset_down", key_down, 0);

        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            check("scan_rotation", col, exp_col);
        end

        // Hold '5', expect one pulse, then time the release debounce.
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        cycles(200);
        check("held_col_frozen", col, 4'b1101);
        wait_drain(0, "press_5");
        check("held_down", key_down, 1);
        pressed = '0;
        n = 0;
        while (key_down && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 11 || n > 14) begin
            errors++;
            $display("FAIL release_latency: %0d cycles, required 11..14", n);
        end
        check("release_key_held", key, 4'h5);
        check("release_resume_col", col, 4'b1011);
        last_key = 4'h5;
        cycles(20);

        // Bounce on '9' too short to pass debounce.
        pressed[2*4+2] = 1'b1;
        cycles(8);
        pressed = '0;
        cycles(30);
        check("bounce_key", key, last_key);
        check("bounce_down", key_down, 0);
        col_snap = col;
        moved = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (col != col_snap) moved = 1'b1;
        end
        check("bounce_scan_resumed", moved, 1);

        // '1' and '7' together is a multi-key pattern; releasing '7' leaves '1'.
        pressed[0*4+0] = 1'b1;
        pressed[2*4+0] = 1'b1;
        cycles(100);
        check("multikey_no_down", key_down, 0);
        pressed[2*4+0] = 1'b0;
        exp_q.push_back(4'h1);
        wait_drain(60, "multikey_release");
        check("multikey_key", key, 4'h1);
        pressed = '0;
        cycles(30);
        check("multikey_released", key_down, 0);
        last_key = 4'h1;

        for (int it = 0; it < 20; it++) begin
            idx        = $urandom_range(0, 15);
            long_press = ($urandom_range(0, 2) != 0);
            hold       = long_press ? $urandom_range(40, 120) : $urandom_range(1, 8);
            pressed[idx] = 1'b1;
            if (long_press) exp_q.push_back(keymap[idx]);
            cycles(hold);
            pressed = '0;
            cycles(30);
            wait_drain(0, "random_press");
            if (long_press) last_key = keymap[idx];
            check("random_key_hold", key, last_key);
            check("random_released", key_down, 0);
        end

        // Reset while 'D' is held, then expect a fresh detection.
        pressed[3*4+3] = 1'b1;
        exp_q.push_back(4'hD);
        wait_drain(60, "press_D");
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_key", key, 4'h0);
        check("midreset_down", key_down, 0);
        check("midreset_col", col, 4'b1110);
        rst_n = 1'b1;
        exp_q.push_back(4'hD);
        wait_drain(60, "redetect_D");
        check("redetect_down", key_down, 1);
        pressed = '0;
        cycles(30);
        check("final_released", key_down, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
